// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings and default sizing for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;
    localparam int STATE_W      = 2;
    localparam int MAX_WAIT_DEF = 15;
    localparam int CNT_W_DEF    = 32;
    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;
endpackage

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: saturating event counter with increment enable and async active-low reset.
module pipe_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (inc_i && cnt_q != '1)
            cnt_q <= cnt_q + W'(1);
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// pipe_ctrl_sequencer: merges load-use, branch redirect and memory-wait hazards into stage enables/flushes.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined; otherwise they read 0.
module pipe_ctrl_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lu_hazard,
    input  logic               br_taken,
    input  logic               exmem_memreq,
    input  logic               dmem_ready,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               idex_write,
    output logic               exmem_write,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               memwb_flush,
    output logic [STATE_W-1:0] state,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events
);
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

    state_e        state_q;
    logic [WW-1:0] wait_q;
    logic          timeout_q;
    logic          freeze;
    logic          fault;
    logic          flow;

    assign freeze = exmem_memreq && !dmem_ready;
    assign fault  = state_q == FAULT;
    assign flow   = !fault && !freeze;

    // A taken branch squashes the dependent instruction, so it overrides load-use.
    assign pc_write    = flow && !(lu_hazard && !br_taken);
    assign ifid_write  = pc_write;
    assign idex_write  = flow;
    assign exmem_write = flow;
    assign ifid_flush  = flow && br_taken;
    assign idex_flush  = flow && (br_taken || lu_hazard);
    assign memwb_flush = !flow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN:
                    if (freeze) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= WW'(1);
                    end
                MEM_WAIT:
                    if (!freeze) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (MAX_WAIT != 0 && wait_q == MAX_W) begin
                        state_q   <= FAULT;
                        timeout_q <= 1'b1;
                    end else if (wait_q != '1) begin
                        wait_q <= wait_q + WW'(1);
                    end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (!pc_write && !fault),
        .cnt_o (stall_cycles)
    );
    pipe_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (ifid_flush),
        .cnt_o (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule
